// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Purpose  : Arbitrates two dual-rail (NULL/DATA) four-phase requesters,
//            instruction fetch and cache, onto one dual-rail memory address
//            channel. Inputs are resynchronised with 2-flop synchronisers.
//            A round-robin tie break alternates the winner when both sources
//            present DATA in the same cycle.
// Ports    : clk           - clock, rising edge
//            rst_n         - asynchronous active-low reset
//            req_instr     - dual-rail address word from instruction fetch
//            ack_out_instr - four-phase acknowledge to instruction fetch
//            req_cache     - dual-rail address word from cache
//            ack_out_cache - four-phase acknowledge to cache
//            addr_to_mem   - dual-rail address word to memory
//            PH0_out       - dual-rail return tag (10 instr, 01 cache, 00 NULL)
//            ack_in_mem    - memory acknowledge (1 consumed, 0 ready)
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] req_instr,
   output logic        ack_out_instr,
   input  logic [15:0] req_cache,
   output logic        ack_out_cache,
   output logic [15:0] addr_to_mem,
   output logic [1:0]  PH0_out,
   input  logic        ack_in_mem
);

   localparam logic [1:0] c_TAG_INSTR = 2'b10;
   localparam logic [1:0] c_TAG_CACHE = 2'b01;
   localparam logic [1:0] c_TAG_NULL  = 2'b00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // A word is DATA only when every rail pair holds exactly one asserted rail.
   function automatic logic f_is_data(input logic [15:0] w);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 8; k++) begin
         ok = ok & (w[2*k+1] ^ w[2*k]);
      end
      return ok;
   endfunction

   // Synchroniser stages
   logic [15:0] r_instr_s1, r_instr_s2;
   logic [15:0] r_cache_s1, r_cache_s2;
   logic        r_ack_s1,   r_ack_s2;

   // Control / output registers
   state_t      r_state;
   logic [15:0] r_addr;
   logic [1:0]  r_tag;
   logic        r_ack_instr;
   logic        r_ack_cache;
   logic        r_grant_cache;   // 1: current transaction belongs to cache
   logic        r_last_cache;    // 1: most recently completed grant was cache

   // Next-state values
   state_t      w_state_nxt;
   logic [15:0] w_addr_nxt;
   logic [1:0]  w_tag_nxt;
   logic        w_ack_instr_nxt;
   logic        w_ack_cache_nxt;
   logic        w_grant_cache_nxt;
   logic        w_last_cache_nxt;

   logic        w_instr_data;
   logic        w_cache_data;
   logic        w_pick_cache;
   logic [15:0] w_granted_word;

   // ------------------------------------------------------------------------
   // 2-flop synchronisers; everything downstream sees only the *_s2 copies.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_instr_s1 <= '0;
         r_instr_s2 <= '0;
         r_cache_s1 <= '0;
         r_cache_s2 <= '0;
         r_ack_s1   <= 1'b0;
         r_ack_s2   <= 1'b0;
      end else begin
         r_instr_s1 <= req_instr;
         r_instr_s2 <= r_instr_s1;
         r_cache_s1 <= req_cache;
         r_cache_s2 <= r_cache_s1;
         r_ack_s1   <= ack_in_mem;
         r_ack_s2   <= r_ack_s1;
      end
   end

   assign w_instr_data = f_is_data(r_instr_s2);
   assign w_cache_data = f_is_data(r_cache_s2);

   // Cache wins when it is the only DATA source, or on a tie when the
   // instruction side was served last.
   assign w_pick_cache = w_cache_data & (~w_instr_data | ~r_last_cache);

   // Word of the source that owns the current transaction; RELEASE waits for
   // this one to return to NULL.
   assign w_granted_word = r_grant_cache ? r_cache_s2 : r_instr_s2;

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= IDLE;
         r_addr        <= '0;
         r_tag         <= c_TAG_NULL;
         r_ack_instr   <= 1'b0;
         r_ack_cache   <= 1'b0;
         r_grant_cache <= 1'b0;
         r_last_cache  <= 1'b1;   // instruction wins the first tie
      end else begin
         r_state       <= w_state_nxt;
         r_addr        <= w_addr_nxt;
         r_tag         <= w_tag_nxt;
         r_ack_instr   <= w_ack_instr_nxt;
         r_ack_cache   <= w_ack_cache_nxt;
         r_grant_cache <= w_grant_cache_nxt;
         r_last_cache  <= w_last_cache_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and output logic. Outputs are registered so that each
   // transition updates the pins on the same edge the state changes.
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt       = r_state;
      w_addr_nxt        = r_addr;
      w_tag_nxt         = r_tag;
      w_ack_instr_nxt   = r_ack_instr;
      w_ack_cache_nxt   = r_ack_cache;
      w_grant_cache_nxt = r_grant_cache;
      w_last_cache_nxt  = r_last_cache;

      case (r_state)
         IDLE: begin
            // A lingering memory acknowledge blocks any new grant.
            if (!r_ack_s2 && (w_instr_data || w_cache_data)) begin
               w_state_nxt       = SEND;
               w_grant_cache_nxt = w_pick_cache;
               w_addr_nxt        = w_pick_cache ? r_cache_s2 : r_instr_s2;
               w_tag_nxt         = w_pick_cache ? c_TAG_CACHE : c_TAG_INSTR;
            end
         end

         SEND: begin
            // Captured word is held regardless of further input activity.
            if (r_ack_s2) begin
               w_state_nxt     = RELEASE;
               w_addr_nxt      = '0;
               w_tag_nxt       = c_TAG_NULL;
               w_ack_instr_nxt = ~r_grant_cache;
               w_ack_cache_nxt = r_grant_cache;
            end
         end

         RELEASE: begin
            if ((w_granted_word == 16'h0000) && !r_ack_s2) begin
               w_state_nxt      = IDLE;
               w_ack_instr_nxt  = 1'b0;
               w_ack_cache_nxt  = 1'b0;
               w_last_cache_nxt = r_grant_cache;
            end
         end

         default: begin
            w_state_nxt     = IDLE;
            w_addr_nxt      = '0;
            w_tag_nxt       = c_TAG_NULL;
            w_ack_instr_nxt = 1'b0;
            w_ack_cache_nxt = 1'b0;
         end
      endcase
   end

   assign addr_to_mem   = r_addr;
   assign PH0_out       = r_tag;
   assign ack_out_instr = r_ack_instr;
   assign ack_out_cache = r_ack_cache;

endmodule
`default_nettype wire
